// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder slice plus a carry flip-flop, fed LSB-first
// from operand shift registers, with valid/ready handshakes on both sides.

// Single-bit full adder evaluated once per clock by the serial stage.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);

endmodule

// Sequential wrapper that streams WIDTH operand bits through full_adder.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy
);

    // Counter needs at least one bit so WIDTH=1 still elaborates.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_next;
    logic             carry;
    logic [CW-1:0]    count;
    logic             fa_sum;
    logic             fa_carry;

    full_adder u_full_adder (
        .a         (sa[0]),
        .b         (sb[0]),
        .carry_in  (carry),
        .sum       (fa_sum),
        .carry_out (fa_carry)
    );

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Next result word: shift right and drop the new sum bit into the MSB.
    // NOTE: assign a default before any partial overwrite so always_comb never infers a latch.
    always_comb begin
        result_next            = result >> 1;
        result_next[WIDTH-1]   = fa_sum;
    end

    // Handshake FSM, operand/result shifting and registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sa        <= '0;
            sb        <= '0;
            result    <= '0;
            carry     <= 1'b0;
            count     <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sa    <= a;
                        sb    <= b;
                        carry <= carry_in;
                        count <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    result <= result_next;
                    carry  <= fa_carry;
                    count  <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        sum       <= result_next;
                        carry_out <= fa_carry;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
